demux4_reg: RTL
===============

Name: demux4_reg

Overview:
- Registered 1-to-4 demultiplexer. It is the distribution counterpart to the team's 4-to-1 selector.
- Routes a WIDTH-bit input word to one of four held output channels. The target channel comes from either the s1/s0 select pins or an internal round-robin pointer.
- Each channel has a one-cycle write strobe, a sticky "new data" flag cleared by a consumer ack, and a sticky overflow flag.
- Sits between a single producer and four consumers on the lab board datapath.

Parameters:
WIDTH, 3, data width of din and each channel output

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear, active-high
din  input  WIDTH  input data word
din_valid  input  1  din is written on this clock edge when high
s0  input  1  select bit 0 (manual mode)
s1  input  1  select bit 1 (manual mode)
auto_mode  input  1  1 = round-robin target, 0 = manual select
ack  input  4  per-channel consumer acknowledge, bit i clears new_flag[i]
y0  output  WIDTH  channel 0 held data
y1  output  WIDTH  channel 1 held data
y2  output  WIDTH  channel 2 held data
y3  output  WIDTH  channel 3 held data
y_valid  output  4  one-hot, one-cycle write strobe
new_flag  output  4  per-channel unread-data flag
ovf  output  4  per-channel sticky overflow
cur_ch  output  2  channel the next write targets

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-operation), all registers cleared immediately:
  - y0..y3 = 0, y_valid = 4'b0000, new_flag = 0, ovf = 0.
  - Internal round-robin pointer rr_ptr = 0.
- Target channel ch:
  - auto_mode=0: ch = {s1,s0}. So 00→y0, 01→y1, 10→y2, 11→y3.
  - auto_mode=1: ch = rr_ptr.
  - cur_ch = ch, combinational.
- Write, on a rising edge with rst_n=1, clr=0, din_valid=1:
  - y[ch] <= din. The other channels hold their values.
  - y_valid <= onehot(ch). It is high for exactly the one cycle after the write edge (latency 1), otherwise 0.
  - new_flag[ch] <= 1.
  - If new_flag[ch] was already 1 and ack[ch]=0 on the same edge: ovf[ch] <= 1. The old data is overwritten.
  - If auto_mode=1: rr_ptr <= rr_ptr+1, modulo 4 (3 wraps to 0).
- No write (din_valid=0): y_valid <= 0, rr_ptr holds.
- Ack:
  - ack[i]=1 clears new_flag[i] on the edge.
  - If ack[i] coincides with a write to channel i, the write wins: new_flag[i] stays 1 and ovf[i] is not set.
  - ack on a channel with new_flag=0 has no effect.
  - ack never clears ovf.
- clr=1 (synchronous, overrides din_valid and ack):
  - Clears y0..y3, y_valid, new_flag, ovf and rr_ptr on the edge.
  - A din_valid in that cycle is dropped.
- Mode switching:
  - rr_ptr holds while auto_mode=0. Returning to auto mode resumes from the held value.
  - auto_mode is sampled on the same edge as the write.
- ovf[i] is sticky. Only clr or reset clear it.
- Outputs y0..y3 hold their values indefinitely between writes.

Test Plan:
- Reset: hold rst_n=0, then release. Expected: y0..y3=0, y_valid=0000, new_flag=0000, ovf=0000, cur_ch=0.
- Manual routing: auto_mode=0, {s1,s0}=10, din=3'b101, din_valid one cycle. Expected:
  - y2=101 and y_valid=0100 for one cycle.
  - new_flag=0100.
  - y0, y1 and y3 unchanged.
- Round robin: auto_mode=1, write din=1,2,3,4,5 on consecutive cycles. Expected:
  - y0=1, y1=2, y2=3, y3=4, then y0=5 (wrap).
  - cur_ch sequence 0,1,2,3,0,1.
  - ovf[0]=1 after the fifth write.
- Ack/write collision: channel 1 has new_flag=1; write to channel 1 with ack=0010 on the same edge. Expected: new_flag[1]=1, ovf[1]=0. A following ack=0010 with no write gives new_flag[1]=0.
- clr priority: clr=1 together with din_valid=1 targeting channel 3 while rr_ptr=2. Expected:
  - All y=0, y_valid=0000, new_flag=0000, ovf=0000, rr_ptr=0.
  - din is not written.
- Async reset mid-write: assert rst_n=0 between clock edges while din_valid=1. Expected: outputs go to 0 before the next edge, and nothing is written on that edge.

Source files
------------

// File: rtl/demux4_reg.sv
// demux4_reg: registered 1-to-4 demultiplexer.
//
// A single producer writes WIDTH-bit words into one of four held output
// channels. The target channel is either the {s1,s0} select pins (manual)
// or an internal round-robin pointer (auto). Each channel carries a
// one-cycle write strobe, a sticky "new data" flag cleared by the consumer
// ack, and a sticky overflow flag raised when unread data is overwritten.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset, clears every register
//   clr        synchronous clear, active-high, beats din_valid and ack
//   din        input data word
//   din_valid  write din to the target channel on this edge
//   s0, s1     manual channel select
//   auto_mode  1 = round-robin target, 0 = manual select
//   ack        per-channel consumer acknowledge (bit i clears new_flag[i])
//   y0..y3     held channel data
//   y_valid    one-hot write strobe, high for the cycle after a write
//   new_flag   per-channel unread-data flag
//   ovf        per-channel sticky overflow
//   cur_ch     channel the next write targets (combinational)
module demux4_reg #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             s0,
    input  logic             s1,
    input  logic             auto_mode,
    input  logic [3:0]       ack,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       y_valid,
    output logic [3:0]       new_flag,
    output logic [3:0]       ovf,
    output logic [1:0]       cur_ch
);

    function automatic logic [3:0] onehot(input logic [1:0] sel);
        logic [3:0] oh;
        oh      = 4'b0000;
        oh[sel] = 1'b1;
        return oh;
    endfunction

    logic [1:0]       rr_ptr_p0;
    logic [1:0]       ch;
    logic [3:0]       wr_oh;
    logic [WIDTH-1:0] y0_p0, y1_p0, y2_p0, y3_p0;
    logic [3:0]       vld_p0;
    logic [3:0]       nf_p0;
    logic [3:0]       ovf_p0;

    assign ch    = auto_mode ? rr_ptr_p0 : {s1, s0};
    assign wr_oh = din_valid ? onehot(ch) : 4'b0000;

    // ---- stage p0: channel registers, flags and pointer ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0_p0     <= '0;
            y1_p0     <= '0;
            y2_p0     <= '0;
            y3_p0     <= '0;
            vld_p0    <= 4'b0000;
            nf_p0     <= 4'b0000;
            ovf_p0    <= 4'b0000;
            rr_ptr_p0 <= 2'd0;
        end else if (clr) begin
            y0_p0     <= '0;
            y1_p0     <= '0;
            y2_p0     <= '0;
            y3_p0     <= '0;
            vld_p0    <= 4'b0000;
            nf_p0     <= 4'b0000;
            ovf_p0    <= 4'b0000;
            rr_ptr_p0 <= 2'd0;
        end else begin
            vld_p0 <= wr_oh;
            if (wr_oh[0]) y0_p0 <= din;
            if (wr_oh[1]) y1_p0 <= din;
            if (wr_oh[2]) y2_p0 <= din;
            if (wr_oh[3]) y3_p0 <= din;
            for (int i = 0; i < 4; i++) begin
                // A write beats a simultaneous ack; an ack on the written
                // channel also means the old word was consumed, so no overflow.
                if (wr_oh[i]) begin
                    nf_p0[i] <= 1'b1;
                    if (nf_p0[i] && !ack[i])
                        ovf_p0[i] <= 1'b1;
                end else if (ack[i]) begin
                    nf_p0[i] <= 1'b0;
                end
            end
            if (din_valid && auto_mode)
                rr_ptr_p0 <= rr_ptr_p0 + 2'd1;
        end
    end

    assign y0       = y0_p0;
    assign y1       = y1_p0;
    assign y2       = y2_p0;
    assign y3       = y3_p0;
    assign y_valid  = vld_p0;
    assign new_flag = nf_p0;
    assign ovf      = ovf_p0;
    assign cur_ch   = ch;

endmodule
